occ_lookup_arbiter: RTL and testbench

- Shares one Occ lookup unit among N_REQ backward-extension requesters (SMEM cores).
- Accepts (k, ks) lookup requests over per-requester valid/ready handshakes and grants them round-robin.
- Sequences the unit's start pulse and waits for its val_valid.
- Returns the 4+4 Occ values to the granted requester, with a watchdog timeout so a hung memory path cannot deadlock the cores.

---
 rtl/occ_lookup_arbiter.sv | 177 +++++++++++++++++
 tb/tb_occ_lookup_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/occ_lookup_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : occ_lookup_arbiter
// Purpose  : Shares one Occ lookup unit among N_REQ backward-extension
//            requesters. Grants round-robin, issues the lookup, waits for
//            the result (with a watchdog), and returns the 4+4 Occ values
//            to the granted requester.
// Revision : 1.0 - initial release
// ============================================================================
module occ_lookup_arbiter #(
  parameter int N_REQ       = 4,
  parameter int KW          = 40,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*KW-1:0] req_k,
  input  logic [N_REQ*KW-1:0] req_ks,
  output logic [N_REQ-1:0]    rsp_valid,
  input  logic [N_REQ-1:0]    rsp_ready,
  output logic [4*KW-1:0]     rsp_k,
  output logic [4*KW-1:0]     rsp_ks,
  output logic                rsp_err,
  output logic [KW-1:0]       occ_k,
  output logic [KW-1:0]       occ_ks,
  output logic                occ_start,
  input  logic [4*KW-1:0]     occ_val_k,
  input  logic [4*KW-1:0]     occ_val_ks,
  input  logic                occ_val_valid,
  output logic                busy,
  output logic [15:0]         stale_cnt
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [CW-1:0] c_WD_LAST  = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [PW-1:0] c_LAST_REQ = PW'(N_REQ - 1);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_ISSUE = 2'd1;
  localparam logic [1:0] c_S_WAIT  = 2'd2;
  localparam logic [1:0] c_S_RESP  = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [PW-1:0]   r_rr_ptr;
  logic [PW-1:0]   r_gnt;
  logic [PW-1:0]   w_gnt;
  logic            w_any;
  logic [CW-1:0]   r_wd_cnt;
  logic            w_wd_expire;
  logic [KW-1:0]   r_occ_k;
  logic [KW-1:0]   r_occ_ks;
  logic [4*KW-1:0] r_rsp_k;
  logic [4*KW-1:0] r_rsp_ks;
  logic            r_rsp_err;
  logic [15:0]     r_stale_cnt;

  // Circular priority search starting at r_rr_ptr; scanning the offsets
  // from farthest to nearest lets the nearest valid requester win.
  always_comb begin
    int idx;
    idx   = 0;
    w_any = 1'b0;
    w_gnt = r_rr_ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = (int'(r_rr_ptr) + i) % N_REQ;
      if (req_valid[idx]) begin
        w_any = 1'b1;
        w_gnt = PW'(idx);
      end
    end
  end

  // A disabled watchdog (TIMEOUT_CYC == 0) never expires.
  assign w_wd_expire = (TIMEOUT_CYC != 0) && (r_wd_cnt == c_WD_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: a result strobe takes priority over watchdog expiry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE:  if (w_any) w_state_nxt = c_S_ISSUE;
      c_S_ISSUE: w_state_nxt = c_S_WAIT;
      c_S_WAIT:  if (occ_val_valid || w_wd_expire) w_state_nxt = c_S_RESP;
      c_S_RESP:  if (rsp_ready[r_gnt]) w_state_nxt = c_S_IDLE;
      default:   w_state_nxt = c_S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    occ_start = 1'b0;
    case (r_state)
      c_S_IDLE:  if (w_any) req_ready[w_gnt] = 1'b1;
      c_S_ISSUE: occ_start = 1'b1;
      c_S_RESP:  rsp_valid[r_gnt] = 1'b1;
      default:   ;
    endcase
  end

  // Datapath: grant capture, watchdog, response capture, round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_gnt     <= '0;
      r_wd_cnt  <= '0;
      r_occ_k   <= '0;
      r_occ_ks  <= '0;
      r_rsp_k   <= '0;
      r_rsp_ks  <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (w_any) begin
            r_gnt    <= w_gnt;
            r_occ_k  <= req_k[int'(w_gnt) * KW +: KW];
            r_occ_ks <= req_ks[int'(w_gnt) * KW +: KW];
          end
        end
        c_S_ISSUE: r_wd_cnt <= '0;
        c_S_WAIT: begin
          if (occ_val_valid) begin
            r_rsp_k   <= occ_val_k;
            r_rsp_ks  <= occ_val_ks;
            r_rsp_err <= 1'b0;
          end else if (w_wd_expire) begin
            r_rsp_k   <= '0;
            r_rsp_ks  <= '0;
            r_rsp_err <= 1'b1;
          end else begin
            r_wd_cnt <= r_wd_cnt + CW'(1);
          end
        end
        c_S_RESP: begin
          if (rsp_ready[r_gnt]) begin
            r_rr_ptr <= (r_gnt == c_LAST_REQ) ? '0 : r_gnt + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Count result strobes that arrive when no lookup is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stale_cnt <= '0;
    end else if (occ_val_valid && (r_state != c_S_WAIT) && (r_stale_cnt != 16'hFFFF)) begin
      r_stale_cnt <= r_stale_cnt + 16'd1;
    end
  end

  assign occ_k     = r_occ_k;
  assign occ_ks    = r_occ_ks;
  assign rsp_k     = r_rsp_k;
  assign rsp_ks    = r_rsp_ks;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != c_S_IDLE);
  assign stale_cnt = r_stale_cnt;

endmodule
`default_nettype wire

// File: tb/tb_occ_lookup_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_occ_lookup_arbiter
// Purpose  : Self-checking bench for occ_lookup_arbiter with a behavioural
//            arbiter/lookup-unit model and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_occ_lookup_arbiter;

  localparam int N  = 4;
  localparam int KW = 40;
  localparam int TO = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*KW-1:0] req_k;
  logic [N*KW-1:0] req_ks;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [4*KW-1:0] rsp_k;
  logic [4*KW-1:0] rsp_ks;
  logic            rsp_err;
  logic [KW-1:0]   occ_k;
  logic [KW-1:0]   occ_ks;
  logic            occ_start;
  logic [4*KW-1:0] occ_val_k;
  logic [4*KW-1:0] occ_val_ks;
  logic            occ_val_valid;
  logic            busy;
  logic [15:0]     stale_cnt;

  occ_lookup_arbiter #(
    .N_REQ       (N),
    .KW          (KW),
    .TIMEOUT_CYC (TO)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_k         (req_k),
    .req_ks        (req_ks),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_k         (rsp_k),
    .rsp_ks        (rsp_ks),
    .rsp_err       (rsp_err),
    .occ_k         (occ_k),
    .occ_ks        (occ_ks),
    .occ_start     (occ_start),
    .occ_val_k     (occ_val_k),
    .occ_val_ks    (occ_val_ks),
    .occ_val_valid (occ_val_valid),
    .busy          (busy),
    .stale_cnt     (stale_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int              rr = 0;
  int              model_stale = 0;
  logic [KW-1:0]   rk  [N];
  logic [KW-1:0]   rks [N];
  logic [4*KW-1:0] vk;
  logic [4*KW-1:0] vks;

  function automatic logic [KW-1:0] rand_kw();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[KW-1:0];
  endfunction

  function automatic logic [4*KW-1:0] rand_wide();
    logic [4*KW-1:0] r;
    for (int s = 0; s < 4; s++) r[s*KW +: KW] = rand_kw();
    return r;
  endfunction

  function automatic int model_grant();
    for (int i = 0; i < N; i++) begin
      if (req_valid[(rr + i) % N]) return (rr + i) % N;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_k[i*KW +: KW]  = rk[i];
      req_ks[i*KW +: KW] = rks[i];
    end
  endtask

  // One complete transaction, starting at an idle cycle (posedge+1).
  task automatic run_txn(input int lat, input int bp, input bit keep, input bit inj, output int g);
    logic [N-1:0]    oh;
    logic [KW-1:0]   ek, eks;
    logic [4*KW-1:0] erk, erks;
    bit              err;
    int              w;
    g = model_grant();
    if (g < 0) begin
      total++; bad++;
      $display("FAIL txn_setup: no pending request, got grant %0d need >=0", g);
      return;
    end
    oh = '0;
    oh[g] = 1'b1;
    ek  = rk[g];
    eks = rks[g];
    // grant cycle
    @(negedge clk);
    total++;
    if (req_ready !== oh || busy !== 1'b0 || rsp_valid !== '0 || stale_cnt !== 16'(model_stale)) begin
      bad++;
      $display("FAIL grant: req_ready=%b busy=%b rsp_valid=%b stale=%0d, need %b 0 0 %0d",
               req_ready, busy, rsp_valid, stale_cnt, oh, model_stale);
    end
    @(posedge clk); #1;
    if (keep) begin
      rk[g]  = rand_kw();
      rks[g] = rand_kw();
    end else begin
      req_valid[g] = 1'b0;
    end
    drive_reqs();
    // issue cycle
    @(negedge clk);
    total++;
    if (occ_start !== 1'b1 || occ_k !== ek || occ_ks !== eks || req_ready !== '0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL issue: start=%b k=%h ks=%h req_ready=%b busy=%b, need 1 %h %h 0 1",
               occ_start, occ_k, occ_ks, req_ready, busy, ek, eks);
    end
    err = (lat > TO);
    w   = err ? TO : lat;
    for (int c = 1; c <= w; c++) begin
      @(posedge clk); #1;
      occ_val_valid = (!err && c == lat);
      occ_val_k     = occ_val_valid ? vk  : rand_wide();
      occ_val_ks    = occ_val_valid ? vks : rand_wide();
      @(negedge clk);
      total++;
      if (occ_start !== 1'b0 || rsp_valid !== '0 || req_ready !== '0 || busy !== 1'b1 || occ_k !== ek) begin
        bad++;
        $display("FAIL wait c=%0d: start=%b rsp_valid=%b req_ready=%b busy=%b occ_k=%h, need 0 0 0 1 %h",
                 c, occ_start, rsp_valid, req_ready, busy, occ_k, ek);
      end
    end
    erk  = err ? '0 : vk;
    erks = err ? '0 : vks;
    @(posedge clk); #1;
    occ_val_valid = inj;
    occ_val_k     = rand_wide();
    occ_val_ks    = rand_wide();
    rsp_ready     = (bp == 0) ? (oh | N'($urandom)) : (N'($urandom) & ~oh);
    for (int b = 0; b <= bp; b++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== oh || rsp_k !== erk || rsp_ks !== erks || rsp_err !== err ||
          req_ready !== '0 || occ_start !== 1'b0 || stale_cnt !== 16'(model_stale)) begin
        bad++;
        $display("FAIL resp b=%0d: valid=%b err=%b k=%h ks=%h stale=%0d rdy=%b start=%b, need %b %b %h %h %0d 0 0",
                 b, rsp_valid, rsp_err, rsp_k, rsp_ks, stale_cnt, req_ready, occ_start,
                 oh, err, erk, erks, model_stale);
      end
      if (b == 0 && inj) model_stale++;
      if (b < bp) begin
        @(posedge clk); #1;
        occ_val_valid = 1'b0;
        occ_val_k     = rand_wide();
        rsp_ready     = (b + 1 == bp) ? (oh | N'($urandom)) : (N'($urandom) & ~oh);
      end
    end
    @(posedge clk); #1;
    rsp_ready     = '0;
    occ_val_valid = 1'b0;
    rr = (g + 1) % N;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    occ_val_valid = 1'b1;
    occ_val_k = rand_wide();
    occ_val_ks = rand_wide();
    for (int i = 0; i < N; i++) begin rk[i] = rand_kw(); rks[i] = rand_kw(); end
    drive_reqs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    occ_val_valid = 1'b0;
    rr = 0;
    model_stale = 0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || req_ready !== '0 || rsp_valid !== '0 || occ_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: busy=%b req_ready=%b rsp_valid=%b start=%b, need all 0",
               busy, req_ready, rsp_valid, occ_start);
    end
    total++;
    if (occ_k !== '0 || occ_ks !== '0 || rsp_k !== '0 || rsp_ks !== '0 || rsp_err !== 1'b0 || stale_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_data: occ_k=%h occ_ks=%h rsp_k=%h rsp_err=%b stale=%0d, need all 0",
               occ_k, occ_ks, rsp_k, rsp_err, stale_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int g;
    req_valid = 4'b0100;
    rk[2]  = 40'h100;
    rks[2] = 40'h1A3;
    drive_reqs();
    vk  = {40'd4, 40'd3, 40'd2, 40'd1};
    vks = {40'd8, 40'd7, 40'd6, 40'd5};
    run_txn(20, 0, 1'b0, 1'b0, g);
    total++;
    if (g != 2 || rr != 3) begin
      bad++;
      $display("FAIL single: grant=%0d rr=%0d, need 2 3", g, rr);
    end
  endtask

  task automatic test_backpressure();
    int g;
    req_valid = 4'b0110;
    drive_reqs();
    vk  = rand_wide();
    vks = rand_wide();
    run_txn(5, 50, 1'b0, 1'b0, g);
    total++;
    if (g != 1) begin
      bad++;
      $display("FAIL backpressure_grant: grant=%0d need 1", g);
    end
  endtask

  task automatic test_timeout();
    int g;
    req_valid = req_valid | 4'b0100;
    drive_reqs();
    vk  = rand_wide();
    vks = rand_wide();
    run_txn(TO + 5, 3, 1'b0, 1'b1, g);
    @(negedge clk);
    total++;
    if (stale_cnt !== 16'd1 || busy !== 1'b0 || rsp_valid !== '0) begin
      bad++;
      $display("FAIL timeout_stale: stale=%0d busy=%b rsp_valid=%b, need 1 0 0", stale_cnt, busy, rsp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout_tie();
    int g;
    req_valid = req_valid | 4'b0001;
    drive_reqs();
    vk  = rand_wide();
    vks = rand_wide();
    run_txn(TO, 0, 1'b0, 1'b0, g);
  endtask

  task automatic test_reset_mid();
    int g;
    req_valid = req_valid | 4'b0001;
    drive_reqs();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || occ_start !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_pre: busy=%b start=%b, need 1 0", busy, occ_start);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    rr = 0;
    model_stale = 0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || rsp_valid !== '0 || occ_start !== 1'b0 || stale_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b rsp_valid=%b start=%b stale=%0d, need 0 0 0 0",
               busy, rsp_valid, occ_start, stale_cnt);
    end
    @(posedge clk); #1;
    occ_val_valid = 1'b1;
    @(posedge clk); #1;
    occ_val_valid = 1'b0;
    model_stale = 1;
    @(negedge clk);
    total++;
    if (stale_cnt !== 16'd1 || busy !== 1'b0 || rsp_valid !== '0) begin
      bad++;
      $display("FAIL late_strobe: stale=%0d busy=%b rsp_valid=%b, need 1 0 0", stale_cnt, busy, rsp_valid);
    end
    @(posedge clk); #1;
    req_valid = 4'b1001;
    drive_reqs();
    vk  = rand_wide();
    vks = rand_wide();
    run_txn(7, 1, 1'b0, 1'b0, g);
    total++;
    if (g != 0) begin
      bad++;
      $display("FAIL reset_mid_grant: grant=%0d need 0", g);
    end
  endtask

  task automatic test_round_robin();
    int g;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    rr = 0;
    model_stale = 0;
    req_valid = '1;
    drive_reqs();
    for (int i = 0; i < 5; i++) begin
      vk  = rand_wide();
      vks = rand_wide();
      run_txn($urandom_range(1, 6), 0, 1'b1, 1'b0, g);
      total++;
      if (g != exp_order[i]) begin
        bad++;
        $display("FAIL rr_order[%0d]: grant=%0d need %0d", i, g, exp_order[i]);
      end
    end
  endtask

  task automatic test_random();
    int g;
    int lat;
    int bp;
    for (int n = 0; n < 40; n++) begin
      req_valid = req_valid | N'($urandom);
      if (req_valid == '0) req_valid[$urandom_range(0, N-1)] = 1'b1;
      drive_reqs();
      vk  = rand_wide();
      vks = rand_wide();
      lat = $urandom_range(1, TO + 3);
      bp  = $urandom_range(0, 3);
      run_txn(lat, bp, 1'($urandom), (bp > 0) && ($urandom_range(0, 1) == 1), g);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_k = '0;
    req_ks = '0;
    occ_val_valid = 1'b0;
    occ_val_k = '0;
    occ_val_ks = '0;
    vk = '0;
    vks = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_timeout();
    test_timeout_tie();
    test_reset_mid();
    test_round_robin();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout: run did not complete, bad=%0d", bad);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
